// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: one outstanding read, returned word held for decode until accepted.
// Best case addr_ok(t) -> data_ok(t+1) -> out_valid(t+2); out_ready low holds the word, flush drops it.
module inst_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h1c000000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic        inst_sram_req,
   output logic        inst_sram_wr,
   output logic [1:0]  inst_sram_size,
   output logic [31:0] inst_sram_addr,
   output logic [3:0]  inst_sram_wstrb,
   output logic [31:0] inst_sram_wdata,
   input  logic        inst_sram_addr_ok,
   input  logic        inst_sram_data_ok,
   input  logic [31:0] inst_sram_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] req_addr, req_addr_n;
   logic [31:0] inst_buf, inst_buf_n;
   logic        discard, discard_n;

   assign inst_sram_req   = (state == REQ);
   assign inst_sram_addr  = req_addr;
   assign inst_sram_wr    = 1'b0;
   assign inst_sram_size  = 2'b10;
   assign inst_sram_wstrb = 4'b0000;
   assign inst_sram_wdata = 32'h0;

   assign out_valid = (state == HOLD) && !flush;
   assign out_pc    = req_addr;
   assign out_inst  = inst_buf;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         req_addr <= RESET_PC;
         inst_buf <= 32'h0;
         discard  <= 1'b0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         req_addr <= req_addr_n;
         inst_buf <= inst_buf_n;
         discard  <= discard_n;
      end
   end

   always_comb begin
      state_n    = state;
      pc_n       = pc;
      req_addr_n = req_addr;
      inst_buf_n = inst_buf;
      discard_n  = discard;
      case (state)
         IDLE: begin
            state_n = REQ;
            if (flush) begin
               pc_n       = flush_pc;
               req_addr_n = flush_pc;
            end else begin
               req_addr_n = pc;
            end
         end
         REQ: begin
            // The issued address stays on the bus; a redirect only marks its response stale.
            if (flush) begin
               pc_n      = flush_pc;
               discard_n = 1'b1;
            end
            if (inst_sram_addr_ok) state_n = WAIT;
         end
         WAIT: begin
            if (inst_sram_data_ok) begin
               if (discard || flush) begin
                  discard_n  = 1'b0;
                  pc_n       = flush ? flush_pc : pc;
                  req_addr_n = flush ? flush_pc : pc;
                  state_n    = REQ;
               end else begin
                  inst_buf_n = inst_sram_rdata;
                  state_n    = HOLD;
               end
            end else if (flush) begin
               pc_n      = flush_pc;
               discard_n = 1'b1;
            end
         end
         HOLD: begin
            if (flush) begin
               pc_n       = flush_pc;
               req_addr_n = flush_pc;
               state_n    = REQ;
            end else if (out_ready) begin
               pc_n       = req_addr + 32'd4;
               req_addr_n = req_addr + 32'd4;
               state_n    = REQ;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: bench drives the bridge handshakes, scoreboard queues hold
// expected request addresses and expected {pc, inst} deliveries.
module tb_inst_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h1c000000;

   logic        clk;
   logic        resetn;
   logic        flush;
   logic [31:0] flush_pc;
   logic        out_ready;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [31:0] inst_sram_addr;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_wdata;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;

   inst_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
      .clk              (clk),
      .resetn           (resetn),
      .flush            (flush),
      .flush_pc         (flush_pc),
      .out_ready        (out_ready),
      .out_valid        (out_valid),
      .out_pc           (out_pc),
      .out_inst         (out_inst),
      .inst_sram_req    (inst_sram_req),
      .inst_sram_wr     (inst_sram_wr),
      .inst_sram_size   (inst_sram_size),
      .inst_sram_addr   (inst_sram_addr),
      .inst_sram_wstrb  (inst_sram_wstrb),
      .inst_sram_wdata  (inst_sram_wdata),
      .inst_sram_addr_ok(inst_sram_addr_ok),
      .inst_sram_data_ok(inst_sram_data_ok),
      .inst_sram_rdata  (inst_sram_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   int checks   = 0;
   int failures = 0;
   int req_cnt  = 0;
   int acc_cnt  = 0;
   int exp_req_total = 0;
   int exp_acc_total = 0;

   logic [31:0] exp_req_q [$];
   logic [63:0] exp_out_q [$];

   logic        prev_req_wait = 1'b0;
   logic [31:0] prev_addr     = 32'h0;
   logic        prev_hold     = 1'b0;
   logic [31:0] prev_pc       = 32'h0;
   logic [31:0] prev_inst     = 32'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_req(input logic [31:0] addr);
      exp_req_q.push_back(addr);
      exp_req_total++;
   endtask

   // One clock cycle with the current inputs; observations are taken mid-cycle.
   task automatic tick();
      logic [31:0] ea;
      logic [63:0] eo;
      @(negedge clk);
      if (prev_req_wait) begin
         chk("req_held", {31'b0, inst_sram_req}, 32'd1);
         chk("addr_held", inst_sram_addr, prev_addr);
      end
      if (prev_hold && !flush) begin
         chk("out_valid_held", {31'b0, out_valid}, 32'd1);
         chk("out_pc_held", out_pc, prev_pc);
         chk("out_inst_held", out_inst, prev_inst);
      end
      if (flush) chk("flush_masks_valid", {31'b0, out_valid}, 32'd0);
      if (inst_sram_req && inst_sram_addr_ok) begin
         req_cnt++;
         checks++;
         assert (exp_req_q.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_req observed=%h expected=none", inst_sram_addr);
         end
         if (exp_req_q.size() != 0) begin
            ea = exp_req_q.pop_front();
            chk("req_addr", inst_sram_addr, ea);
         end
      end
      if (out_valid && out_ready) begin
         acc_cnt++;
         checks++;
         assert (exp_out_q.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_out observed=%h/%h expected=none", out_pc, out_inst);
         end
         if (exp_out_q.size() != 0) begin
            eo = exp_out_q.pop_front();
            chk("out_pc", out_pc, eo[63:32]);
            chk("out_inst", out_inst, eo[31:0]);
         end
      end
      prev_req_wait = inst_sram_req && !inst_sram_addr_ok;
      prev_addr     = inst_sram_addr;
      prev_hold     = out_valid && !out_ready;
      prev_pc       = out_pc;
      prev_inst     = out_inst;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(output int n);
      n = 0;
      while (!inst_sram_req && n < 20) begin
         tick();
         n++;
      end
      chk("req_timeout", {31'b0, inst_sram_req}, 32'd1);
   endtask

   // Full fetch: addr_ok after a_dly, data_ok d_dly later, decode stalls r_dly cycles.
   task automatic fetch(input int a_dly, input int d_dly, input int r_dly,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic garbage, output int n);
      push_req(addr);
      exp_out_q.push_back({addr, data});
      exp_acc_total++;
      out_ready = 1'b0;
      wait_req(n);
      repeat (a_dly) tick();
      inst_sram_addr_ok = 1'b1;
      tick();
      inst_sram_addr_ok = 1'b0;
      repeat (d_dly) tick();
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = data;
      tick();
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'h0;
      chk("valid_after_data", {31'b0, out_valid}, 32'd1);
      for (int i = 0; i < r_dly; i++) begin
         inst_sram_data_ok = garbage && (i == 1);
         inst_sram_rdata   = 32'hbadbad00;
         tick();
      end
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'h0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      #1;
      chk("rst_req", {31'b0, inst_sram_req}, 32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_pc", out_pc, RST_PC);
      chk("rst_out_inst", out_inst, 32'h0);
      prev_req_wait = 1'b0;
      prev_hold     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      chk("req_before_first_edge", {31'b0, inst_sram_req}, 32'd0);
      tick();
      chk("first_req", {31'b0, inst_sram_req}, 32'd1);
      chk("first_req_addr", inst_sram_addr, RST_PC);
   endtask

   initial begin
      int n;
      resetn            = 1'b1;
      flush             = 1'b0;
      flush_pc          = 32'h0;
      out_ready         = 1'b0;
      inst_sram_addr_ok = 1'b0;
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'h0;
      #2;
      do_reset();
      chk("const_wr", {31'b0, inst_sram_wr}, 32'd0);
      chk("const_size", {30'b0, inst_sram_size}, 32'd2);
      chk("const_wstrb", {28'b0, inst_sram_wstrb}, 32'd0);
      chk("const_wdata", inst_sram_wdata, 32'h0);

      // Best-case pipeline from reset
      fetch(0, 0, 0, 32'h1c000000, 32'h02800c0c, 1'b0, n);
      chk("best_case_no_wait", n, 32'd0);
      chk("next_req_t3", {31'b0, inst_sram_req}, 32'd1);
      chk("next_req_addr", inst_sram_addr, 32'h1c000004);

      // Slow addr_ok, decode stall, stray data_ok during HOLD
      fetch(5, 0, 4, 32'h1c000004, 32'h11112222, 1'b1, n);

      // Flush in WAIT, stale data arrives two cycles later
      push_req(32'h1c000008);
      wait_req(n);
      out_ready = 1'b1;
      inst_sram_addr_ok = 1'b1; tick(); inst_sram_addr_ok = 1'b0;
      flush = 1'b1; flush_pc = 32'h1c000100; tick(); flush = 1'b0;
      tick();
      inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'hdeadbeef; tick();
      inst_sram_data_ok = 1'b0;
      chk("stale_not_presented", {31'b0, out_valid}, 32'd0);
      chk("redirect_req_addr", inst_sram_addr, 32'h1c000100);
      fetch(0, 1, 0, 32'h1c000100, 32'h33334444, 1'b0, n);

      // Two flushes while REQ waits for addr_ok; last target wins
      push_req(32'h1c000104);
      wait_req(n);
      flush = 1'b1; flush_pc = 32'h1c000180; tick();
      flush_pc = 32'h1c000200; tick();
      flush = 1'b0;
      tick();
      inst_sram_addr_ok = 1'b1; tick(); inst_sram_addr_ok = 1'b0;
      out_ready = 1'b1;
      inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'hbad00001; tick();
      inst_sram_data_ok = 1'b0;
      chk("req_flush_dropped", {31'b0, out_valid}, 32'd0);
      chk("req_flush_target", inst_sram_addr, 32'h1c000200);
      fetch(1, 0, 2, 32'h1c000200, 32'h55556666, 1'b0, n);

      // Flush coinciding with data_ok
      push_req(32'h1c000204);
      wait_req(n);
      inst_sram_addr_ok = 1'b1; tick(); inst_sram_addr_ok = 1'b0;
      out_ready = 1'b1;
      inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'hbad00002;
      flush = 1'b1; flush_pc = 32'h1c000300; tick();
      flush = 1'b0; inst_sram_data_ok = 1'b0;
      chk("dataok_flush_target", inst_sram_addr, 32'h1c000300);
      chk("dataok_flush_req", {31'b0, inst_sram_req}, 32'd1);
      fetch(0, 0, 0, 32'h1c000300, 32'h77778888, 1'b0, n);

      // Flush coinciding with out_ready in HOLD
      push_req(32'h1c000304);
      wait_req(n);
      inst_sram_addr_ok = 1'b1; tick(); inst_sram_addr_ok = 1'b0;
      inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'hbad00003; tick();
      inst_sram_data_ok = 1'b0;
      chk("hold_valid_before_flush", {31'b0, out_valid}, 32'd1);
      out_ready = 1'b1; flush = 1'b1; flush_pc = 32'h1c000400; tick();
      flush = 1'b0; out_ready = 1'b0;
      chk("hold_flush_target", inst_sram_addr, 32'h1c000400);
      fetch(0, 0, 1, 32'h1c000400, 32'h9999aaaa, 1'b0, n);

      // PC wrap at the top of the address space
      push_req(32'h1c000404);
      wait_req(n);
      inst_sram_addr_ok = 1'b1; tick(); inst_sram_addr_ok = 1'b0;
      flush = 1'b1; flush_pc = 32'hfffffffc; tick(); flush = 1'b0;
      inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'hbad00004; tick();
      inst_sram_data_ok = 1'b0;
      chk("wrap_start_addr", inst_sram_addr, 32'hfffffffc);
      fetch(0, 0, 0, 32'hfffffffc, 32'hbbbbcccc, 1'b0, n);
      chk("wrap_next_addr", inst_sram_addr, 32'h00000000);
      fetch(0, 0, 0, 32'h00000000, 32'hddddeeee, 1'b0, n);

      // Reset while a response is outstanding
      push_req(32'h00000004);
      wait_req(n);
      inst_sram_addr_ok = 1'b1; tick(); inst_sram_addr_ok = 1'b0;
      #1;
      do_reset();
      fetch(0, 0, 0, RST_PC, 32'h0123abcd, 1'b0, n);

      chk("req_queue_drained", exp_req_q.size(), 32'd0);
      chk("out_queue_drained", exp_out_q.size(), 32'd0);
      chk("req_count", req_cnt, exp_req_total);
      chk("accept_count", acc_cnt, exp_acc_total);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction-fetch request controller that drives the instruction port (port 1) of the SRAM-like side of the AXI bridge and delivers fetched instructions to the decode stage. It keeps a PC, issues one read at a time, and buffers the returned word until decode accepts it. On a control-flow redirect it discards the in-flight response, so stale instructions never reach decode.

## Interface
Parameters:
- RESET_PC, 32'h1c000000, PC loaded at reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- flush  in  1  redirect request this cycle.
- flush_pc  in  32  redirect target; valid when flush=1.
- out_ready  in  1  decode can accept an instruction this cycle.
- out_valid  out  1  out_pc/out_inst hold a valid instruction.
- out_pc  out  32  address of the presented instruction.
- out_inst  out  32  presented instruction word.
- inst_sram_req  out  1  read request to the bridge.
- inst_sram_wr  out  1  constant 0.
- inst_sram_size  out  2  constant 2'b10 (4 bytes).
- inst_sram_addr  out  32  request address.
- inst_sram_wstrb  out  4  constant 0.
- inst_sram_wdata  out  32  constant 0.
- inst_sram_addr_ok  in  1  bridge accepted the request.
- inst_sram_data_ok  in  1  read data returned.
- inst_sram_rdata  in  32  returned word; valid with data_ok.

## Operation
- Registers: state {IDLE, REQ, WAIT, HOLD}, pc, req_addr, inst_buf, discard (1 bit).
- No more than one request is outstanding. The bridge returns responses in order, so a 1-bit discard flag is sufficient.
- Combinational outputs:
  - inst_sram_req = (state==REQ); inst_sram_addr = req_addr.
  - out_valid = (state==HOLD) && !flush; out_pc = req_addr; out_inst = inst_buf.
- IDLE: next cycle goes to REQ, with req_addr<=pc. If flush, pc<=flush_pc and req_addr<=flush_pc.
- REQ: req and req_addr are held stable until addr_ok; a request is never withdrawn.
  - flush without addr_ok: pc<=flush_pc, discard<=1. Stay in REQ; the old address is still issued.
  - addr_ok: go to WAIT. If flush occurs in the same cycle, also pc<=flush_pc and discard<=1.
- WAIT:
  - data_ok && (discard || flush): drop the data, discard<=0, req_addr<=(flush ? flush_pc : pc), pc likewise. Go to REQ.
  - data_ok otherwise: inst_buf<=rdata, go to HOLD.
  - flush without data_ok: pc<=flush_pc, discard<=1, stay in WAIT.
- HOLD:
  - flush: drop the buffer, pc<=flush_pc, req_addr<=flush_pc, go to REQ. Flush wins over out_ready.
  - out_valid && out_ready: pc<=req_addr+4, req_addr<=req_addr+4, go to REQ.
- Repeated flushes: the last flush_pc wins. discard stays 1 and is never counted more than once.
- PC arithmetic: 32-bit, wraps modulo 2^32 (32'hfffffffc+4 = 0).
- data_ok in IDLE, REQ or HOLD is a protocol error. It is ignored, with no state change.

## Timing
- Reset (resetn low, takes effect asynchronously):
  - state=IDLE, pc=req_addr=RESET_PC, discard=0, inst_buf=0.
  - Outputs: req=0, out_valid=0, out_pc=RESET_PC, out_inst=0.
- First req=1 appears in the first cycle after the first clk edge with resetn high.
- Best-case pipeline: addr_ok in cycle t, data_ok in t+1, out_valid in t+2, next req in t+3 if out_ready is 1 in t+2.
- Sustained throughput is at most one instruction per 3 cycles.
- Reset asserted mid-transaction returns to IDLE immediately. The bridge is reset by the same resetn, so no stale response has to be tracked.
- The req/addr stability rule is checked each cycle: while req=1 and addr_ok=0, the address must not change in the following cycle.

## Test plan
- Reset release, addr_ok=1 immediately, data_ok one cycle later with rdata=32'h02800c0c, out_ready=1 → req at 32'h1c000000, then out_valid with out_pc=32'h1c000000 and out_inst=32'h02800c0c, then next req at 32'h1c000004.
- addr_ok delayed 5 cycles and out_ready held 0 for 4 cycles → req/addr stable throughout; out_valid stays 1 with an unchanged inst until accepted; exactly one request issued per instruction.
- flush (flush_pc=32'h1c000100) while in WAIT, data_ok 2 cycles later → that data is never presented; next req at 32'h1c000100.
- flush while in REQ with addr_ok=0, then addr_ok → old address still accepted, its response dropped, next req at flush_pc.
- Flush coinciding with data_ok, and flush coinciding with out_ready in HOLD → out_valid=0 in that cycle; next req at flush_pc; no handshake counted.
- pc=32'hfffffffc accepted by decode → next req address 32'h00000000.
